// File: rtl/button_event_decoder_pkg.sv
// Shared state encodings and default timing constants for the button event decoder
// and the time/alarm-setting FSM that consumes its events.
package button_event_decoder_pkg;

    typedef enum logic [1:0] {
        BtnArm     = 2'd0,
        BtnIdle    = 2'd1,
        BtnPressed = 2'd2,
        BtnLong    = 2'd3
    } btn_state_e;

    // 10 ms tick: 1 s long press, 200 ms auto-repeat.
    localparam int unsigned DefLongCycles   = 100;
    localparam int unsigned DefRepeatCycles = 20;
    localparam int unsigned DefCntW         = 8;

    function automatic logic is_tracking(input btn_state_e st);
        return (st == BtnPressed) || (st == BtnLong);
    endfunction

endpackage

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle short-press, long-press and
// auto-repeat events. All outputs are registered.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DefLongCycles,
    parameter int unsigned REPEAT_CYCLES = DefRepeatCycles,
    parameter int unsigned CNT_W         = DefCntW
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic held,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_q, held_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        unique case (state_q)
            // A button held through reset must be released before it can count.
            BtnArm: begin
                if (!btn) begin
                    state_d = BtnIdle;
                end
            end
            BtnIdle: begin
                if (btn) begin
                    state_d = BtnPressed;
                    cnt_d   = CNT_W'(1);
                end
            end
            BtnPressed: begin
                if (!btn) begin
                    state_d = BtnIdle;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else if (cnt_q == LongLast) begin
                    state_d = BtnLong;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BtnLong: begin
                if (!btn) begin
                    state_d = BtnIdle;
                    cnt_d   = '0;
                end else if (cnt_q == RepeatLast) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        held_d = is_tracking(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BtnArm;
            cnt_q    <= '0;
            held_q   <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            held_q   <= held_d;
            short_q  <= short_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
        end
    end

    assign held         = held_q;
    assign short_press  = short_q;
    assign long_press   = long_q;
    assign repeat_pulse = repeat_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with LONG_CYCLES=5, REPEAT_CYCLES=3.
module tb_button_event_decoder;

    localparam logic [3:0] Z = 4'b0000;
    localparam logic [3:0] H = 4'b1000;  // {held, short, long, repeat}
    localparam logic [3:0] S = 4'b0100;
    localparam logic [3:0] L = 4'b0010;
    localparam logic [3:0] R = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic held, short_press, long_press, repeat_pulse;

    logic [3:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int vec_idx  = 0;

    button_event_decoder #(
        .LONG_CYCLES  (5),
        .REPEAT_CYCLES(3),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .held        (held),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; the expected outputs after the next rising edge
    // are queued at the same moment.
    task automatic step(input logic r, input logic b, input logic [3:0] e);
        @(negedge clk);
        rst = r;
        btn = b;
        exp_q.push_back(e);
    endtask

    task automatic steps(input int n, input logic r, input logic b, input logic [3:0] e);
        for (int i = 0; i < n; i++) step(r, b, e);
    endtask

    // Monitor: every output cycle is popped and compared, away from the clock edge.
    always @(posedge clk) begin
        logic [3:0] got;
        logic [3:0] want;
        #2;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {held, short_press, long_press, repeat_pulse};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL vec%0d outputs {held,short,long,rep}: got %b expected %b",
                         vec_idx, got, want);
            end
            n_checks++;
            if ((32'(short_press) + 32'(long_press) + 32'(repeat_pulse)) > 1) begin
                n_fail++;
                $display("FAIL vec%0d pulse_exclusive: got %b expected at most one pulse",
                         vec_idx, got[2:0]);
            end
            vec_idx++;
        end
    end

    initial begin
        // Reset, then a 3-sample short press.
        steps(2, 1'b1, 1'b0, Z);
        step(1'b0, 1'b0, Z);
        steps(3, 1'b0, 1'b1, H);
        step(1'b0, 1'b0, S);
        step(1'b0, 1'b0, Z);

        // Long press of 12 samples with repeats after samples 8 and 11.
        steps(4, 1'b0, 1'b1, H);
        step(1'b0, 1'b1, H | L);
        steps(2, 1'b0, 1'b1, H);
        step(1'b0, 1'b1, H | R);
        steps(2, 1'b0, 1'b1, H);
        step(1'b0, 1'b1, H | R);
        step(1'b0, 1'b1, H);
        step(1'b0, 1'b0, Z);
        step(1'b0, 1'b0, Z);

        // Boundary: 4 samples is short, exactly 5 is long only.
        steps(4, 1'b0, 1'b1, H);
        step(1'b0, 1'b0, S);
        step(1'b0, 1'b0, Z);
        steps(4, 1'b0, 1'b1, H);
        step(1'b0, 1'b1, H | L);
        step(1'b0, 1'b0, Z);
        step(1'b0, 1'b0, Z);

        // Held through reset: nothing until released, then a 2-sample press.
        steps(2, 1'b1, 1'b1, Z);
        steps(10, 1'b0, 1'b1, Z);
        step(1'b0, 1'b0, Z);
        steps(2, 1'b0, 1'b1, H);
        step(1'b0, 1'b0, S);
        step(1'b0, 1'b0, Z);

        // Reset on the third sample of a press; stays armed until btn drops.
        steps(2, 1'b0, 1'b1, H);
        step(1'b1, 1'b1, Z);
        steps(3, 1'b0, 1'b1, Z);
        step(1'b0, 1'b0, Z);
        step(1'b0, 1'b1, H);
        step(1'b0, 1'b0, S);
        step(1'b0, 1'b0, Z);

        // Back-to-back single-sample presses, and a press right after a release.
        step(1'b0, 1'b1, H);
        step(1'b0, 1'b0, S);
        step(1'b0, 1'b1, H);
        step(1'b0, 1'b0, S);
        step(1'b0, 1'b1, H);
        step(1'b0, 1'b0, S);
        steps(2, 1'b0, 1'b0, Z);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #4;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
